fft_ring_node_sched: RTL and testbench



---
 rtl/fft_ring_pkg.sv | 28 ++
 rtl/fft_ring_oreg.sv | 31 +++
 rtl/fft_ring_node_sched.sv | 136 +++++++++++++
 tb/tb_fft_ring_node_sched.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_ring_pkg.sv
// Shared types for the FFT ring node: message format, arbiter states and
// the helper that maps an ODST message's fft_pt onto a ring node index.
package fft_ring_pkg;

  typedef enum logic [0:0] {
    ODST  = 1'b0,
    MDEST = 1'b1
  } te_fft_ring_msg_type;

  typedef enum logic [0:0] {
    RING_PRI = 1'b0,
    INJ_TURN = 1'b1
  } te_fft_ring_arb_state;

  typedef struct packed {
    te_fft_ring_msg_type msg_type;
    logic [7:0]          src_node_id;
    logic [15:0]         fft_pt;
    logic [31:0]         payload;
  } ts_fft_ring_msg;

  // num_nodes is a power of two, so masking keeps the low log2(num_nodes) bits
  function automatic logic [15:0] odst_dest(input logic [15:0] fft_pt,
                                            input int          num_nodes);
    return fft_pt & 16'(num_nodes - 1);
  endfunction

endpackage

// File: rtl/fft_ring_oreg.sv
// One-entry ready/valid output register; accepts a new message when empty
// or when the current one drains in the same cycle.
module fft_ring_oreg
  import fft_ring_pkg::*;
(
  input  logic           clk,
  input  logic           rst_n,
  input  logic           load,
  input  ts_fft_ring_msg din,
  output logic           can_load,
  output logic           valid,
  input  logic           ready,
  output ts_fft_ring_msg msg
);

  assign can_load = !valid || ready;

  // msg only changes on load, so it holds steady while valid && !ready
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      msg   <= '0;
    end else if (load) begin
      valid <= 1'b1;
      msg   <= din;
    end else if (ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/fft_ring_node_sched.sv
// FFT ring node: classifies upstream ring traffic into absorb/eject/forward,
// arbitrates ring forwarding against local injection with a starvation bound.
module fft_ring_node_sched
  import fft_ring_pkg::*;
#(
  parameter int NODE_ID      = 0,
  parameter int NUM_NODES    = 4,
  parameter int STARVE_MAX   = 3,
  parameter int MAX_INFLIGHT = 2
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              ring_in_valid,
  output logic                              ring_in_ready,
  input  ts_fft_ring_msg                    ring_in_msg,
  output logic                              ring_out_valid,
  input  logic                              ring_out_ready,
  output ts_fft_ring_msg                    ring_out_msg,
  input  logic                              inj_valid,
  output logic                              inj_ready,
  input  ts_fft_ring_msg                    inj_msg,
  output logic                              ej_valid,
  input  logic                              ej_ready,
  output ts_fft_ring_msg                    ej_msg,
  output logic                              bcast_done,
  output logic [$clog2(MAX_INFLIGHT+1)-1:0] inflight_cnt
);

  localparam int IW = $clog2(MAX_INFLIGHT + 1);
  localparam int SW = $clog2(STARVE_MAX + 1);

  te_fft_ring_arb_state state;
  logic [SW-1:0]        starve_cnt;

  logic           in_mdest, in_own, in_for_me;
  logic           cls_a, cls_b, cls_c, cls_d;
  logic           rout_free, ej_free;
  logic           fwd_ready, fwd_xfer;
  logic           inj_eligible, inj_go;
  logic           absorb, inj_inc;
  logic           rout_load, ej_load;
  ts_fft_ring_msg rout_din;

  assign in_mdest  = (ring_in_msg.msg_type == MDEST);
  assign in_own    = (ring_in_msg.src_node_id == 8'(NODE_ID));
  assign in_for_me = (odst_dest(ring_in_msg.fft_pt, NUM_NODES) == 16'(NODE_ID));

  assign cls_a = in_mdest && in_own;
  assign cls_b = in_mdest && !in_own;
  assign cls_c = !in_mdest && in_for_me;
  assign cls_d = !in_mdest && !in_for_me;

  // Forwarding is only possible in RING_PRI; a broadcast copy also needs ej
  assign fwd_ready = (state == RING_PRI) && rout_free && (cls_d || (cls_b && ej_free));
  assign fwd_xfer  = ring_in_valid && fwd_ready;

  assign ring_in_ready = cls_a || (cls_c && ej_free) || fwd_ready;

  assign inj_eligible = inj_valid &&
                        !((inj_msg.msg_type == MDEST) && (inflight_cnt == IW'(MAX_INFLIGHT)));
  assign inj_go       = inj_eligible && rout_free && !fwd_xfer;
  assign inj_ready    = inj_go;

  assign absorb  = ring_in_valid && cls_a && (inflight_cnt != '0);
  assign inj_inc = inj_go && (inj_msg.msg_type == MDEST);

  assign rout_load = fwd_xfer || inj_go;
  assign rout_din  = fwd_xfer ? ring_in_msg : inj_msg;
  assign ej_load   = ring_in_valid && ring_in_ready && (cls_b || cls_c);

  fft_ring_oreg u_ring_out (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (rout_load),
    .din      (rout_din),
    .can_load (rout_free),
    .valid    (ring_out_valid),
    .ready    (ring_out_ready),
    .msg      (ring_out_msg)
  );

  fft_ring_oreg u_ej (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (ej_load),
    .din      (ring_in_msg),
    .can_load (ej_free),
    .valid    (ej_valid),
    .ready    (ej_ready),
    .msg      (ej_msg)
  );

  // Arbiter, starvation counter, inflight tracking and the bcast_done pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= RING_PRI;
      starve_cnt   <= '0;
      inflight_cnt <= '0;
      bcast_done   <= 1'b0;
    end else begin
      bcast_done <= absorb;

      if (inj_inc && !absorb) begin
        inflight_cnt <= inflight_cnt + 1'b1;
      end else if (!inj_inc && absorb) begin
        inflight_cnt <= inflight_cnt - 1'b1;
      end

      case (state)
        RING_PRI: begin
          if (fwd_xfer && inj_eligible) begin
            if (starve_cnt >= SW'(STARVE_MAX - 1)) begin
              state      <= INJ_TURN;
              starve_cnt <= SW'(STARVE_MAX);
            end else begin
              starve_cnt <= starve_cnt + 1'b1;
            end
          end else begin
            starve_cnt <= '0;
          end
        end
        INJ_TURN: begin
          if (inj_go || !inj_eligible) begin
            state      <= RING_PRI;
            starve_cnt <= '0;
          end
        end
        default: begin
          state      <= RING_PRI;
          starve_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fft_ring_node_sched.sv
// Directed bench for fft_ring_node_sched at NODE_ID=2, NUM_NODES=4,
// STARVE_MAX=3, MAX_INFLIGHT=2 with hand-computed expectations.
module tb_fft_ring_node_sched;
  import fft_ring_pkg::*;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           ring_in_valid, ring_in_ready;
  ts_fft_ring_msg ring_in_msg;
  logic           ring_out_valid, ring_out_ready;
  ts_fft_ring_msg ring_out_msg;
  logic           inj_valid, inj_ready;
  ts_fft_ring_msg inj_msg;
  logic           ej_valid, ej_ready;
  ts_fft_ring_msg ej_msg;
  logic           bcast_done;
  logic [1:0]     inflight_cnt;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  fft_ring_node_sched #(
    .NODE_ID(2), .NUM_NODES(4), .STARVE_MAX(3), .MAX_INFLIGHT(2)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .ring_in_valid  (ring_in_valid),
    .ring_in_ready  (ring_in_ready),
    .ring_in_msg    (ring_in_msg),
    .ring_out_valid (ring_out_valid),
    .ring_out_ready (ring_out_ready),
    .ring_out_msg   (ring_out_msg),
    .inj_valid      (inj_valid),
    .inj_ready      (inj_ready),
    .inj_msg        (inj_msg),
    .ej_valid       (ej_valid),
    .ej_ready       (ej_ready),
    .ej_msg         (ej_msg),
    .bcast_done     (bcast_done),
    .inflight_cnt   (inflight_cnt)
  );

  function automatic ts_fft_ring_msg mk(input te_fft_ring_msg_type t, input int src,
                                        input int pt, input logic [31:0] pl);
    ts_fft_ring_msg m;
    m.msg_type    = t;
    m.src_node_id = 8'(src);
    m.fft_pt      = 16'(pt);
    m.payload     = pl;
    return m;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    ring_in_valid = 1'b0; ring_in_msg = '0;
    inj_valid = 1'b0; inj_msg = '0;
    ring_out_ready = 1'b1; ej_ready = 1'b1;
    #2;
    n_vec++;
    if ({ring_out_valid, ej_valid, bcast_done, inflight_cnt} !== 5'b0) begin
      n_bad++;
      $display("[TB] FAIL reset_outputs: got rov=%b ejv=%b bd=%b cnt=%0d, want all 0",
               ring_out_valid, ej_valid, bcast_done, inflight_cnt);
    end
    n_vec++;
    if (ring_out_msg !== '0 || ej_msg !== '0) begin
      n_bad++;
      $display("[TB] FAIL reset_msgs: got rom=%h ejm=%h, want 0", ring_out_msg, ej_msg);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_route();
    ts_fft_ring_msg m;
    m = mk(ODST, 0, 6, 32'hA006);
    ring_in_msg = m; ring_in_valid = 1'b1;
    #1;
    n_vec++;
    if (ring_in_ready !== 1'b1) begin
      n_bad++; $display("[TB] FAIL route_eject_ready: got %b want 1", ring_in_ready);
    end
    tick();
    ring_in_valid = 1'b0;
    n_vec++;
    if (ej_valid !== 1'b1 || ej_msg !== m || ring_out_valid !== 1'b0) begin
      n_bad++;
      $display("[TB] FAIL route_eject: got ejv=%b ejm=%h rov=%b want ejv=1 ejm=%h rov=0",
               ej_valid, ej_msg, ring_out_valid, m);
    end

    m = mk(ODST, 0, 5, 32'hA005);
    ring_in_msg = m; ring_in_valid = 1'b1;
    tick();
    ring_in_valid = 1'b0;
    n_vec++;
    if (ring_out_valid !== 1'b1 || ring_out_msg !== m || ej_valid !== 1'b0) begin
      n_bad++;
      $display("[TB] FAIL route_forward: got rov=%b rom=%h ejv=%b want rov=1 rom=%h ejv=0",
               ring_out_valid, ring_out_msg, ej_valid, m);
    end

    m = mk(MDEST, 2, 0, 32'hB001);
    inj_msg = m; inj_valid = 1'b1;
    #1;
    n_vec++;
    if (inj_ready !== 1'b1) begin
      n_bad++; $display("[TB] FAIL route_inj_ready: got %b want 1", inj_ready);
    end
    tick();
    inj_valid = 1'b0;
    n_vec++;
    if (inflight_cnt !== 2'd1 || ring_out_msg !== m) begin
      n_bad++;
      $display("[TB] FAIL route_inj: got cnt=%0d rom=%h want cnt=1 rom=%h",
               inflight_cnt, ring_out_msg, m);
    end

    ring_in_msg = m; ring_in_valid = 1'b1;
    tick();
    ring_in_valid = 1'b0;
    n_vec++;
    if (bcast_done !== 1'b1 || ej_valid !== 1'b0 || ring_out_valid !== 1'b0 || inflight_cnt !== 2'd0) begin
      n_bad++;
      $display("[TB] FAIL route_own_return: got bd=%b ejv=%b rov=%b cnt=%0d want 1 0 0 0",
               bcast_done, ej_valid, ring_out_valid, inflight_cnt);
    end
    tick();
    n_vec++;
    if (bcast_done !== 1'b0) begin
      n_bad++; $display("[TB] FAIL route_bcast_pulse: got bd=%b want 0", bcast_done);
    end
  endtask

  task automatic test_bcast_copy();
    ts_fft_ring_msg first, m;
    first = mk(ODST, 0, 6, 32'hC000);
    m     = mk(MDEST, 1, 0, 32'hC001);
    ej_ready = 1'b0;
    ring_in_msg = first; ring_in_valid = 1'b1;
    tick();
    ring_in_msg = m;
    #1;
    n_vec++;
    if (ring_in_ready !== 1'b0) begin
      n_bad++; $display("[TB] FAIL bcast_stall: got ready=%b want 0", ring_in_ready);
    end
    tick();
    n_vec++;
    if (ring_in_ready !== 1'b0 || ej_msg !== first || ring_out_valid !== 1'b0) begin
      n_bad++;
      $display("[TB] FAIL bcast_stall_hold: got ready=%b ejm=%h rov=%b want 0 %h 0",
               ring_in_ready, ej_msg, ring_out_valid, first);
    end
    ej_ready = 1'b1;
    #1;
    n_vec++;
    if (ring_in_ready !== 1'b1) begin
      n_bad++; $display("[TB] FAIL bcast_release: got ready=%b want 1", ring_in_ready);
    end
    tick();
    ring_in_valid = 1'b0;
    n_vec++;
    if (ring_out_valid !== 1'b1 || ring_out_msg !== m || ej_valid !== 1'b1 || ej_msg !== m) begin
      n_bad++;
      $display("[TB] FAIL bcast_copy: got rov=%b rom=%h ejv=%b ejm=%h want both valid with %h",
               ring_out_valid, ring_out_msg, ej_valid, ej_msg, m);
    end
    tick();
  endtask

  task automatic test_starvation();
    ts_fft_ring_msg fwd, im;
    logic exp_rr, exp_ir;
    fwd = mk(ODST, 0, 5, 32'hD000);
    im  = mk(ODST, 2, 1, 32'hD0FF);
    ring_in_msg = fwd; ring_in_valid = 1'b1;
    inj_msg = im; inj_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      exp_rr = (i != 3);
      exp_ir = (i == 3);
      #1;
      n_vec++;
      if (ring_in_ready !== exp_rr || inj_ready !== exp_ir) begin
        n_bad++;
        $display("[TB] FAIL starve_cycle%0d: got rr=%b ir=%b want rr=%b ir=%b",
                 i, ring_in_ready, inj_ready, exp_rr, exp_ir);
      end
      tick();
      if (i == 3) begin
        inj_valid = 1'b0;
        n_vec++;
        if (ring_out_msg !== im) begin
          n_bad++;
          $display("[TB] FAIL starve_inj_msg: got %h want %h", ring_out_msg, im);
        end
      end
    end
    ring_in_valid = 1'b0;
    tick();
  endtask

  task automatic test_inflight();
    ts_fft_ring_msg m1, m2, m3, ret;
    m1  = mk(MDEST, 2, 0, 32'hE001);
    m2  = mk(MDEST, 2, 0, 32'hE002);
    m3  = mk(MDEST, 2, 0, 32'hE003);
    ret = mk(MDEST, 2, 0, 32'hE0FF);
    inj_valid = 1'b1;
    inj_msg = m1; tick();
    inj_msg = m2; tick();
    inj_msg = m3;
    #1;
    n_vec++;
    if (inflight_cnt !== 2'd2 || inj_ready !== 1'b0) begin
      n_bad++;
      $display("[TB] FAIL inflight_limit: got cnt=%0d ir=%b want cnt=2 ir=0", inflight_cnt, inj_ready);
    end
    tick();
    n_vec++;
    if (inflight_cnt !== 2'd2 || inj_ready !== 1'b0) begin
      n_bad++;
      $display("[TB] FAIL inflight_hold: got cnt=%0d ir=%b want cnt=2 ir=0", inflight_cnt, inj_ready);
    end
    ring_in_msg = ret; ring_in_valid = 1'b1;
    tick();
    ring_in_valid = 1'b0;
    n_vec++;
    if (inflight_cnt !== 2'd1 || bcast_done !== 1'b1 || inj_ready !== 1'b1) begin
      n_bad++;
      $display("[TB] FAIL inflight_return: got cnt=%0d bd=%b ir=%b want cnt=1 bd=1 ir=1",
               inflight_cnt, bcast_done, inj_ready);
    end
    tick();
    inj_valid = 1'b0;
    n_vec++;
    if (inflight_cnt !== 2'd2 || ring_out_msg !== m3) begin
      n_bad++;
      $display("[TB] FAIL inflight_third: got cnt=%0d rom=%h want cnt=2 rom=%h",
               inflight_cnt, ring_out_msg, m3);
    end
    ring_in_valid = 1'b1;
    tick();
    inj_msg = m1; inj_valid = 1'b1;
    tick();
    ring_in_valid = 1'b0; inj_valid = 1'b0;
    n_vec++;
    if (inflight_cnt !== 2'd1 || bcast_done !== 1'b1) begin
      n_bad++;
      $display("[TB] FAIL inflight_same_cycle: got cnt=%0d bd=%b want cnt=1 bd=1", inflight_cnt, bcast_done);
    end
    ring_in_valid = 1'b1;
    tick();
    n_vec++;
    if (inflight_cnt !== 2'd0) begin
      n_bad++; $display("[TB] FAIL inflight_to_zero: got cnt=%0d want 0", inflight_cnt);
    end
    tick();
    ring_in_valid = 1'b0;
    n_vec++;
    if (inflight_cnt !== 2'd0 || bcast_done !== 1'b0 || ej_valid !== 1'b0) begin
      n_bad++;
      $display("[TB] FAIL inflight_drop: got cnt=%0d bd=%b ejv=%b want 0 0 0",
               inflight_cnt, bcast_done, ej_valid);
    end
    tick();
  endtask

  task automatic test_backpressure_reset();
    ts_fft_ring_msg z;
    z = mk(ODST, 3, 5, 32'hF00D);
    inj_msg = mk(MDEST, 2, 0, 32'hF001); inj_valid = 1'b1;
    tick();
    inj_valid = 1'b0;
    tick();
    ring_out_ready = 1'b0;
    ring_in_msg = z; ring_in_valid = 1'b1;
    tick();
    ring_in_msg = mk(ODST, 3, 1, 32'hF0F0);
    for (int i = 0; i < 5; i++) begin
      tick();
      n_vec++;
      if (ring_out_valid !== 1'b1 || ring_out_msg !== z) begin
        n_bad++;
        $display("[TB] FAIL bp_stable%0d: got rov=%b rom=%h want rov=1 rom=%h",
                 i, ring_out_valid, ring_out_msg, z);
      end
    end
    n_vec++;
    if (ring_in_ready !== 1'b0 || inflight_cnt !== 2'd1) begin
      n_bad++;
      $display("[TB] FAIL bp_ready: got rr=%b cnt=%0d want rr=0 cnt=1", ring_in_ready, inflight_cnt);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_vec++;
    if (ring_out_valid !== 1'b0 || ej_valid !== 1'b0 || inflight_cnt !== 2'd0 || bcast_done !== 1'b0) begin
      n_bad++;
      $display("[TB] FAIL bp_async_reset: got rov=%b ejv=%b cnt=%0d bd=%b want all 0",
               ring_out_valid, ej_valid, inflight_cnt, bcast_done);
    end
    ring_in_valid = 1'b0;
    ring_out_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    n_vec++;
    if (ring_out_valid !== 1'b0 || ej_valid !== 1'b0 || ring_out_msg !== '0) begin
      n_bad++;
      $display("[TB] FAIL bp_after_reset: got rov=%b ejv=%b rom=%h want 0 0 0",
               ring_out_valid, ej_valid, ring_out_msg);
    end
  endtask

  initial begin
    test_reset();
    test_route();
    test_bcast_copy();
    test_starvation();
    test_inflight();
    test_backpressure_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
